// File: rtl/seq_div_top.sv
// Sequential unsigned divider using repeated subtraction.
// The dividend and divisor arrive on the shared data_in bus on consecutive
// cycles, starting with the start pulse. The controller FSM sequences the
// datapath registers A (dividend), B (divisor), R (remainder) and Q (quotient).
module seq_div_top #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    CHECK,
    SUB,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic             dbz_reg;
  logic             r_ge_b;

  // Compare that guards each subtraction step and ends the SUB loop
  always_comb begin
    r_ge_b = (r_reg >= b_reg);
  end

  // Controller: state sequencing; start is honoured only in IDLE and DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= LOAD_B;
        LOAD_B:  state <= CHECK;
        CHECK:   state <= (b_reg == '0) ? DONE : SUB;
        SUB:     if (!r_ge_b) state <= DONE;
        DONE:    if (start) state <= LOAD_B;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture, initialisation and repeated subtraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      r_reg   <= '0;
      q_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) a_reg <= data_in;
        end
        LOAD_B: begin
          b_reg <= data_in;
        end
        CHECK: begin
          r_reg <= a_reg;
          if (b_reg == '0) begin
            q_reg   <= '1;
            dbz_reg <= 1'b1;
          end else begin
            q_reg   <= '0;
            dbz_reg <= 1'b0;
          end
        end
        SUB: begin
          if (r_ge_b) begin
            r_reg <= r_reg - b_reg;
            q_reg <= q_reg + WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore status outputs decoded from the state register
  always_comb begin
    done = (state == DONE);
    busy = (state == LOAD_B) || (state == CHECK) || (state == SUB);
  end

  assign div_by_zero = dbz_reg;
  assign quotient    = q_reg;
  assign remainder   = r_reg;

endmodule

// File: tb/tb_seq_div_top.sv
// Scoreboard bench for seq_div_top: each issued operation pushes its
// hand-computed result; a monitor pops and checks it when done rises.
module tb_seq_div_top;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data_in;
  logic        done;
  logic        busy;
  logic        div_by_zero;
  logic [15:0] quotient;
  logic [15:0] remainder;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
    int          e0;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  logic done_prev = 1'b0;

  seq_div_top #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: compares each completed result against the scoreboard head
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_done: done rose at cycle %0d, expected no result", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_quotient"}, 32'(quotient), 32'(e.q));
          chk({e.name, "_remainder"}, 32'(remainder), 32'(e.r));
          chk({e.name, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
          chk({e.name, "_latency"}, 32'(cyc - e.e0), 32'(e.lat));
        end
      end
      done_prev = done;
    end
  end

  // Issues start+dividend, then the divisor; returns just after E0's follow-up edge E0.
  // Must be called away from a rising edge; the next rising edge is E0.
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                       input bit track);
    exp_t e;
    e.q    = eq;
    e.r    = er;
    e.dbz  = edbz;
    e.lat  = edbz ? 2 : int'(eq) + 3;
    e.e0   = cyc + 1;
    e.name = name;
    if (track) sb.push_back(e);
    start   = 1'b1;
    data_in = a;
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = b;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s_timeout: %0d results still pending after %0d cycles, expected 0", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    #12;
    chk("reset_done", 32'(done), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_dbz", 32'(div_by_zero), 0);
    chk("reset_quotient", 32'(quotient), 0);
    chk("reset_remainder", 32'(remainder), 0);
    rst_n = 1'b1;
    #11;

    // Scenario 1: 9/4 with busy profile
    do_op("s1_9div4", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 1'b1);
    chk("s1_busy_after_E0", 32'(busy), 1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("s1_busy_after_E%0d", i), 32'(busy), 1);
    end
    @(posedge clk); #1;
    chk("s1_busy_after_E5", 32'(busy), 0);
    chk("s1_done_after_E5", 32'(done), 1);
    wait_idle("s1", 50);

    // Scenario 2: A<B, then A==B restarted from DONE
    do_op("s2_4div9", 16'd4, 16'd9, 16'd0, 16'd4, 1'b0, 1'b1);
    wait_idle("s2a", 50);
    do_op("s2_7div7", 16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 1'b1);
    wait_idle("s2b", 50);

    // Scenario 3: divide by zero, then div_by_zero clears at next CHECK
    do_op("s3_25div0", 16'd25, 16'd0, 16'hFFFF, 16'd25, 1'b1, 1'b1);
    wait_idle("s3a", 50);
    do_op("s3_100div10", 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, 1'b1);
    chk("s3_dbz_after_E0", 32'(div_by_zero), 1);
    @(posedge clk); #1;
    chk("s3_dbz_after_E1", 32'(div_by_zero), 1);
    @(posedge clk); #1;
    chk("s3_dbz_after_E2", 32'(div_by_zero), 0);
    wait_idle("s3b", 50);

    // Boundary: zero dividend with nonzero and zero divisor
    do_op("bd_0div5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 1'b1);
    wait_idle("bd_a", 50);
    do_op("bd_0div0", 16'd0, 16'd0, 16'hFFFF, 16'd0, 1'b1, 1'b1);
    wait_idle("bd_b", 50);

    // Scenario 4: start pulse during SUB must be ignored
    do_op("s4_busy_start", 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    start   = 1'b1;
    data_in = 16'd3;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_idle("s4", 50);

    // Scenario 5: asynchronous reset mid-SUB, then 9/4 again
    do_op("s5_abort", 16'd100, 16'd10, 16'd10, 16'd0, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_done", 32'(done), 0);
    chk("s5_rst_busy", 32'(busy), 0);
    chk("s5_rst_dbz", 32'(div_by_zero), 0);
    chk("s5_rst_quotient", 32'(quotient), 0);
    chk("s5_rst_remainder", 32'(remainder), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    #2;
    do_op("s5_9div4", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 1'b1);
    wait_idle("s5", 50);

    // Scenario 6: upper bound operands
    do_op("s6_max_div_max", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 1'b1);
    wait_idle("s6a", 50);
    do_op("s6_max_div_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 1'b1);
    wait_idle("s6b", 70000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seq_div_top.md
Name: seq_div_top

Overview:
- Sequential unsigned divider using repeated subtraction. It is the inverse companion of the sequential multiplier block.
- Operands arrive over the same single shared `data_in` bus: dividend first, then divisor. Control is a `start` pulse and a `done` flag.
- Internally split into a controller FSM and a datapath with registers A (dividend), B (divisor), R (remainder accumulator) and Q (quotient counter).

Parameters:
WIDTH, 16, operand, quotient and remainder width in bits

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE or DONE
data_in  input  WIDTH  dividend on the start cycle, divisor on the following cycle
done  output  1  high while in DONE; results valid
busy  output  1  high in LOAD_B, CHECK and SUB
div_by_zero  output  1  high with done when divisor was 0
quotient  output  WIDTH  Q register
remainder  output  WIDTH  R register

Behaviour:
- Reset (asynchronous on rst_n low):
  - state=IDLE.
  - A, B, R, Q = 0.
  - done=0, busy=0, div_by_zero=0.
  - Reset wins over everything, including mid-operation; the operation is abandoned with no partial result.
- Outputs:
  - done and busy are Moore outputs decoded from the state register.
  - quotient = Q and remainder = R, both direct register outputs.
- States and transitions, counting rising edges from E0, the edge at which start=1 is sampled:
  - IDLE: at E0, if start=1 then A<=data_in, go to LOAD_B. Otherwise hold.
  - LOAD_B (E1): B<=data_in, go to CHECK. Unconditional; start is ignored.
  - CHECK (E2):
    - If B==0: Q<=all-ones, R<=A, div_by_zero<=1, go to DONE.
    - Else: Q<=0, R<=A, div_by_zero<=0, go to SUB.
  - SUB, on each edge:
    - If R>=B (unsigned): R<=R-B, Q<=Q+1, stay in SUB.
    - Else: go to DONE; R and Q hold.
  - DONE: done=1. Q, R and div_by_zero hold.
    - start=1 behaves exactly as in IDLE: A<=data_in, go to LOAD_B, done drops after that edge.
    - Otherwise stay in DONE indefinitely.
- Latency:
  - B!=0 with quotient q: done is high after edge E(q+3).
  - B==0: done is high after edge E2.
- Arithmetic:
  - All operations are unsigned WIDTH-bit.
  - R-B never underflows because it is guarded by the compare.
  - Q cannot overflow: q <= 2^WIDTH-1 when B>=1.
  - Worst case (B=1, A=2^WIDTH-1) is 2^WIDTH+2 cycles; accepted.
- Boundary conditions:
  - start asserted in LOAD_B, CHECK or SUB is ignored; it is neither queued nor restarts.
  - A<B gives q=0, R=A, and one SUB cycle.
  - A==B gives q=1, R=0.
  - A=0, B!=0 gives q=0, R=0.
  - A=0, B=0 takes the div_by_zero path: Q=all-ones, R=0.
  - div_by_zero is cleared only in CHECK of a new operation or by reset.
  - quotient and remainder are undefined to the consumer while busy=1. They must still follow the register rules above, since the bench checks them.

Test Plan:
1. Basic divide: reset, then start=1 with data_in=9 at E0, then data_in=4 at E1.
   - Expected: busy=1 from after E0 to E4.
   - Expected: done=1 after E5, quotient=2, remainder=1, div_by_zero=0.
2. Small dividend and equal operands:
   - 4/9: done after E3, quotient=0, remainder=4.
   - Then restart from DONE with 7/7: done after E4, quotient=1, remainder=0.
3. Divide by zero: 25/0.
   - Expected: done after E2, div_by_zero=1, quotient=16'hFFFF, remainder=25.
   - Follow with 100/10: div_by_zero clears at that operation's E2; done after E13, quotient=10, remainder=0.
4. Start while busy: begin 100/10, then pulse start with data_in=3 during SUB.
   - Expected: ignored; result is still quotient=10, remainder=0, done after E13.
5. Reset mid-operation: begin 100/10, drive rst_n low asynchronously (between edges) during SUB.
   - Expected immediately: state=IDLE and all outputs/registers 0.
   - After release, 9/4 completes exactly as in scenario 1.
6. Upper bound: 65535/65535 and 65535/1.
   - 65535/65535: quotient=1, remainder=0, done after E4.
   - 65535/1: quotient=65535, remainder=0, done after E65538; no wrap of Q.
